// File: rtl/program_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// program_sequencer_pkg : op-code width and sequencing op encodings. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package program_sequencer_pkg;
   localparam int OP_WIDTH = 3;

   localparam logic [OP_WIDTH-1:0] OP_NEXT = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_JMP  = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_JZ   = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_JNZ  = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_BRA  = 3'd4;
   localparam logic [OP_WIDTH-1:0] OP_CALL = 3'd5;
   localparam logic [OP_WIDTH-1:0] OP_RET  = 3'd6;
   localparam logic [OP_WIDTH-1:0] OP_HOLD = 3'd7;
endpackage

`default_nettype wire

// File: rtl/call_stack.sv
// ----------------------------------------------------------------------------
// call_stack : LIFO of return addresses with occupancy counter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module call_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [IW-1:0]    wr_idx, rd_idx;

   always_comb begin
      wr_idx  = IW'(count_q);
      rd_idx  = IW'(count_q - CW'(1));
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      rdata   = mem_q[rd_idx];
      mem_d   = mem_q;
      count_d = count_q;
      if (push && !full) begin
         mem_d[wr_idx] = wdata;
         count_d       = count_q + CW'(1);
      end else if (pop && !empty) begin
         count_d = count_q - CW'(1);
      end
   end

   // Only the occupancy is reset; stale entries are never read.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end
endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
// ----------------------------------------------------------------------------
// program_sequencer : program counter sequencer; call stack built only when
// PROGRAM_SEQUENCER_CALL_STACK_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int LAST_ADDR   = 127,
   parameter int RESET_ADDR  = 0,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic                  zero_flag,
   input  logic [ADDR_WIDTH-1:0] target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  stack_overflow,
   output logic                  stack_underflow
);
   localparam logic [ADDR_WIDTH-1:0] LAST_PC  = ADDR_WIDTH'(LAST_ADDR);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

   if (STACK_DEPTH < 1) begin : g_depth_check
      $error("program_sequencer: STACK_DEPTH must be at least 1");
   end

   logic [ADDR_WIDTH-1:0] pc_q, pc_d, seq;

`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
   logic                  push, pop, full, empty;
   logic [ADDR_WIDTH-1:0] rdata;
   logic                  ovf_q, ovf_d, unf_q, unf_d;

   call_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_call_stack (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   (seq),
      .rdata   (rdata),
      .full    (full),
      .empty   (empty)
   );
`endif

   always_comb begin
      seq  = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_WIDTH'(1);
      pc_d = pc_q;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
      push  = 1'b0;
      pop   = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
`endif
      if (enable) begin
         case (op)
            OP_NEXT: pc_d = seq;
            OP_JMP:  pc_d = target;
            OP_JZ:   pc_d = zero_flag ? target : seq;
            OP_JNZ:  pc_d = zero_flag ? seq : target;
            // Same-width add is the sign-extended offset modulo 2^ADDR_WIDTH.
            OP_BRA:  pc_d = pc_q + target;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
            OP_CALL: begin
               if (!full) begin
                  push = 1'b1;
                  pc_d = target;
               end else begin
                  pc_d  = seq;
                  ovf_d = 1'b1;
               end
            end
            OP_RET: begin
               if (!empty) begin
                  pop  = 1'b1;
                  pc_d = rdata;
               end else begin
                  pc_d  = seq;
                  unf_d = 1'b1;
               end
            end
`else
            OP_CALL: pc_d = target;
            OP_RET:  pc_d = seq;
`endif
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pc_q <= RESET_PC;
      else          pc_q <= pc_d;
   end

   assign pc = pc_q;

`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;
`else
   assign stack_overflow  = 1'b0;
   assign stack_underflow = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ----------------------------------------------------------------------------
// tb_program_sequencer : scoreboard bench with a queue-based reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_program_sequencer;
   localparam int LAST  = 127;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] op = 3'd0;
   logic       zero_flag = 1'b0;
   logic [7:0] target = 8'd0;
   logic [7:0] pc;
   logic       stack_overflow, stack_underflow;

   program_sequencer #(
      .ADDR_WIDTH  (8),
      .LAST_ADDR   (LAST),
      .RESET_ADDR  (0),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .enable          (enable),
      .op              (op),
      .zero_flag       (zero_flag),
      .target          (target),
      .pc              (pc),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] pc;
      logic       ovf;
      logic       unf;
      string      name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_pc   = 0;
   int   m_stk[$];

   // Reference model: addresses as plain integers, stack as a queue.
   task automatic cyc(input logic en, input logic [2:0] o, input logic zf,
                      input logic [7:0] t, input string nm);
      exp_t e;
      int   s;
      @(negedge clock);
      enable = en; op = o; zero_flag = zf; target = t;
      s = (m_pc == LAST) ? 0 : (m_pc + 1) % 256;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      e.name = nm;
      if (en) begin
         case (o)
            3'd0: m_pc = s;
            3'd1: m_pc = int'(t);
            3'd2: m_pc = zf ? int'(t) : s;
            3'd3: m_pc = zf ? s : int'(t);
            3'd4: m_pc = (m_pc + int'($signed(t)) + 256) % 256;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
            3'd5: begin
               if (m_stk.size() < DEPTH) begin
                  m_stk.push_back(s);
                  m_pc = int'(t);
               end else begin
                  m_pc  = s;
                  e.ovf = 1'b1;
               end
            end
            3'd6: begin
               if (m_stk.size() > 0) m_pc = m_stk.pop_back();
               else begin
                  m_pc  = s;
                  e.unf = 1'b1;
               end
            end
`else
            3'd5: m_pc = int'(t);
            3'd6: m_pc = s;
`endif
            default: ;
         endcase
      end
      e.pc = 8'(m_pc);
      q.push_back(e);
   endtask

   task automatic reset_mid(input string nm);
      @(negedge clock);
      enable = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (pc !== 8'd0 || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
         errors++;
         $display("FAIL %s: pc=%h ovf=%b unf=%b, expected pc=00 ovf=0 unf=0",
                  nm, pc, stack_overflow, stack_underflow);
      end
      m_pc = 0;
      m_stk.delete();
      #1 reset_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (pc !== e.pc || stack_overflow !== e.ovf || stack_underflow !== e.unf) begin
               errors++;
               $display("FAIL %s: pc=%h ovf=%b unf=%b, expected pc=%h ovf=%b unf=%b",
                        e.name, pc, stack_overflow, stack_underflow, e.pc, e.ovf, e.unf);
            end
         end
      end
   end

   initial begin : stim
      #3;
      checks++;
      if (pc !== 8'd0 || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: pc=%h ovf=%b unf=%b, expected pc=00 ovf=0 unf=0",
                  pc, stack_overflow, stack_underflow);
      end
      #9 reset_n = 1'b1;

      for (int i = 0; i < 128; i++) cyc(1'b1, 3'd0, 1'b0, 8'h00, "wrap_next");

      cyc(1'b1, 3'd1, 1'b0, 8'h05, "jmp5");
      cyc(1'b1, 3'd2, 1'b0, 8'h40, "jz_nottaken");
      cyc(1'b1, 3'd1, 1'b0, 8'h05, "jmp5");
      cyc(1'b1, 3'd2, 1'b1, 8'h40, "jz_taken");
      cyc(1'b1, 3'd1, 1'b0, 8'h05, "jmp5");
      cyc(1'b1, 3'd3, 1'b0, 8'h40, "jnz_taken");
      cyc(1'b1, 3'd1, 1'b0, 8'h05, "jmp5");
      cyc(1'b1, 3'd3, 1'b1, 8'h40, "jnz_nottaken");

      cyc(1'b1, 3'd1, 1'b0, 8'h02, "jmp2");
      cyc(1'b1, 3'd4, 1'b0, 8'hFC, "bra_back");
      cyc(1'b1, 3'd4, 1'b0, 8'h05, "bra_fwd_wrap");

      reset_mid("reset_nest");
      cyc(1'b1, 3'd1, 1'b0, 8'd10, "jmp10");
      cyc(1'b1, 3'd5, 1'b0, 8'h20, "call20");
      cyc(1'b1, 3'd5, 1'b0, 8'h30, "call30");
      cyc(1'b1, 3'd6, 1'b0, 8'h00, "ret1");
      cyc(1'b1, 3'd6, 1'b0, 8'h00, "ret2");

      reset_mid("reset_limits");
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'd5, 1'b0, 8'(8'h10 + i), "call_fill");
      cyc(1'b1, 3'd1, 1'b0, 8'h50, "jmp50");
      cyc(1'b1, 3'd5, 1'b0, 8'h70, "call_overflow");
      cyc(1'b1, 3'd0, 1'b0, 8'h00, "after_overflow");
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'd6, 1'b0, 8'h00, "ret_drain");
      cyc(1'b1, 3'd1, 1'b0, 8'h60, "jmp60");
      cyc(1'b1, 3'd6, 1'b0, 8'h00, "ret_underflow");
      cyc(1'b1, 3'd0, 1'b0, 8'h00, "after_underflow");

      for (int i = 0; i < 3; i++) cyc(1'b0, 3'd1, 1'b1, 8'hAA, "hold_disabled");
      cyc(1'b1, 3'd5, 1'b0, 8'h22, "call_a");
      cyc(1'b1, 3'd5, 1'b0, 8'h33, "call_b");
      reset_mid("reset_mid_call");
      cyc(1'b1, 3'd6, 1'b0, 8'h00, "ret_after_reset");

      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
             1'($urandom), 8'($urandom), "random");

      for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clock);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 8 and SHALL set the width of the program counter and of all addresses.
REQ-002 The parameter LAST_ADDR SHALL default to 127 and SHALL be the highest address reached before sequential wrap to 0.
REQ-003 The parameter RESET_ADDR SHALL default to 0 and SHALL be the pc value loaded at reset.
REQ-004 The parameter STACK_DEPTH SHALL default to 4 and SHALL set the number of call-stack entries (minimum 1).
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  advance/update permitted this cycle.
REQ-009 op  input  3  sequencing operation, encoded as in REQ-013.
REQ-010 zero_flag  input  1  ALU zero flag for conditional ops.
REQ-011 target  input  ADDR_WIDTH  absolute target, or two's-complement offset for BRA.
REQ-012 pc  output  ADDR_WIDTH  registered current address; stack_overflow  output  1  one-cycle error pulse; stack_underflow  output  1  one-cycle error pulse.

Function
REQ-013 op encoding SHALL be: 0 NEXT, 1 JMP, 2 JZ, 3 JNZ, 4 BRA, 5 CALL, 6 RET, 7 HOLD.
REQ-014 seq SHALL be defined as (pc == LAST_ADDR) ? 0 : pc+1.
REQ-015 All updates SHALL occur on the rising clock edge when enable=1, giving one-cycle latency from op to the new pc.
REQ-016 With enable=0, pc and the stack SHALL hold, and both error pulses SHALL be 0.
REQ-017 NEXT SHALL load seq, JMP SHALL load target, JZ SHALL load target if zero_flag=1 else seq, JNZ SHALL load target if zero_flag=0 else seq, and HOLD SHALL keep pc.
REQ-018 BRA SHALL load pc + sign-extended target modulo 2^ADDR_WIDTH, with no LAST_ADDR wrap applied.
REQ-019 CALL with the stack not full SHALL push seq and load target in the same edge.
REQ-020 CALL with the stack full SHALL neither push nor jump, SHALL load seq, and SHALL assert stack_overflow for one cycle.
REQ-021 RET with the stack not empty SHALL pop and load the popped address.
REQ-022 RET with the stack empty SHALL load seq and SHALL assert stack_underflow for one cycle.
REQ-023 Error pulses SHALL be registered and SHALL be high only in the cycle following the offending op.
REQ-024 Stack occupancy SHALL range from 0 to STACK_DEPTH; exactly one push or pop SHALL occur per edge at most.

Reset
REQ-025 When reset_n=0, the block SHALL immediately set pc=RESET_ADDR, stack occupancy=0, stack_overflow=0 and stack_underflow=0, regardless of clock or enable.
REQ-026 Reset asserted mid-call-sequence SHALL discard all stack contents; a subsequent RET SHALL underflow.

Configuration
REQ-027 Macro PROGRAM_SEQUENCER_CALL_STACK_EN SHALL, when defined, compile in the call stack with the behaviour of REQ-019 to REQ-022.
REQ-028 When PROGRAM_SEQUENCER_CALL_STACK_EN is undefined, CALL SHALL behave as JMP, RET SHALL behave as NEXT, no stack storage SHALL be built, and both error outputs SHALL be tied to 0.

Structure
REQ-029 The package program_sequencer_pkg SHALL hold the op encoding constants and the op-code width.
REQ-030 The LIFO storage and occupancy counter SHALL be a sub-module named call_stack, with ports push, pop, wdata, rdata, full and empty.

Verification
REQ-031 Wrap: reset, then NEXT for 128 enabled cycles -> pc goes 0..127 then 0.
REQ-032 Conditional: pc=5, JZ target=0x40 with zero_flag=0 -> pc=6; with zero_flag=1 -> pc=0x40; JNZ behaves inversely.
REQ-033 Relative: pc=0x02, BRA target=0xFC -> pc=0xFE; pc=0xFE, BRA target=0x05 -> pc=0x03.
REQ-034 Nesting: pc=10 CALL 0x20, then CALL 0x30, RET, RET -> pc 0x20, 0x30, 0x21, 11.
REQ-035 Limits (STACK_DEPTH=4): a 5th CALL from pc=0x50 -> pc=0x51 and stack_overflow high for one cycle; RET on an empty stack from pc=0x60 -> pc=0x61 and stack_underflow high for one cycle.
REQ-036 Reset/hold: enable=0 for 3 cycles -> pc unchanged; assert reset_n=0 between clock edges after 2 CALLs -> pc=RESET_ADDR at once, and the next RET underflows.
